// File: rtl/clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_multi
// Purpose  : Bank of NCH independent programmable clock dividers. Each channel
//            counts 0..D-1 and produces a registered divided clock
//            (high while cnt < D>>1) plus a one-cycle tick per period.
//            Divisor writes to a running channel are held pending and take
//            effect at the channel's next wrap, so a period is never cut short.
// Ports    : iCLK     - system clock, rising edge
//            iRST_N   - asynchronous active-low reset
//            iEN      - per-channel run enable
//            iWR      - one-cycle divisor write strobe
//            iWR_CH   - target channel of the write
//            iWR_DIV  - divisor value (must be >= 2)
//            iSYNC    - (CLKGEN_SYNC_EN only) realign all enabled channels
//            oCLK     - per-channel divided clock
//            oTICK    - per-channel one-cycle pulse per period
//            oBUSY    - per-channel pending-divisor flag
//            oERR     - one-cycle pulse after a rejected write
// Options  : `define CLKGEN_SYNC_EN adds the iSYNC input.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_multi #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int DEF_DIV = 50
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic [NCH-1:0] iEN,
  input  logic           iWR,
  input  logic [3:0]     iWR_CH,
  input  logic [DW-1:0]  iWR_DIV,
`ifdef CLKGEN_SYNC_EN
  input  logic           iSYNC,
`endif
  output logic [NCH-1:0] oCLK,
  output logic [NCH-1:0] oTICK,
  output logic [NCH-1:0] oBUSY,
  output logic           oERR
);

  localparam logic [DW-1:0] c_def_div = DW'(DEF_DIV);
  localparam logic [DW-1:0] c_min_div = DW'(2);
  localparam logic [DW-1:0] c_one     = DW'(1);

  logic [DW-1:0]  r_cnt  [NCH];
  logic [DW-1:0]  r_div  [NCH];
  logic [DW-1:0]  r_pend [NCH];
  logic [NCH-1:0] r_busy;
  logic [NCH-1:0] r_clk;
  logic [NCH-1:0] r_tick;
  logic           r_err;

  logic           w_wr_ok;
  logic           w_sync;
  logic [NCH-1:0] w_hit;
  logic [NCH-1:0] w_wrap;
  logic [DW-1:0]  w_next_div [NCH];

  // Channel index is widened by one bit so NCH=16 compares correctly.
  assign w_wr_ok = iWR && (iWR_DIV >= c_min_div) && ({1'b0, iWR_CH} < 5'(NCH));

`ifdef CLKGEN_SYNC_EN
  assign w_sync = iSYNC;
`else
  assign w_sync = 1'b0;
`endif

  // Divisor to load at a reload point: a write landing on the same edge wins
  // over the pending value, which in turn wins over the current divisor.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      w_hit[ch]      = w_wr_ok && (iWR_CH == 4'(ch));
      w_wrap[ch]     = iEN[ch] && (r_cnt[ch] == (r_div[ch] - c_one));
      w_next_div[ch] = w_hit[ch] ? iWR_DIV : (r_busy[ch] ? r_pend[ch] : r_div[ch]);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_cnt[ch]  <= '0;
        r_div[ch]  <= c_def_div;
        r_pend[ch] <= c_def_div;
      end
      r_busy <= '0;
      r_clk  <= '0;
      r_tick <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= iWR && !w_wr_ok;
      for (int ch = 0; ch < NCH; ch++) begin
        if (w_hit[ch]) begin
          r_pend[ch] <= iWR_DIV;
        end
        if (!iEN[ch]) begin
          // Idle channel: counter parked at 0, divisor changes apply at once.
          r_cnt[ch]  <= '0;
          r_clk[ch]  <= 1'b0;
          r_tick[ch] <= 1'b0;
          r_div[ch]  <= w_next_div[ch];
          r_busy[ch] <= 1'b0;
        end else begin
          // Outputs are registered from the current count, so oTICK appears
          // in the cycle after cnt==D-1 and oCLK follows cnt by one cycle.
          r_tick[ch] <= w_wrap[ch] && !w_sync;
          r_clk[ch]  <= (r_cnt[ch] < (r_div[ch] >> 1));
          if (w_wrap[ch] || w_sync) begin
            r_cnt[ch]  <= '0;
            r_div[ch]  <= w_next_div[ch];
            r_busy[ch] <= 1'b0;
          end else begin
            r_cnt[ch] <= r_cnt[ch] + c_one;
            if (w_hit[ch]) begin
              r_busy[ch] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign oCLK  = r_clk;
  assign oTICK = r_tick;
  assign oBUSY = r_busy;
  assign oERR  = r_err;

endmodule
`default_nettype wire

// File: doc/clkgen_multi.md
CLKGEN_MULTI -- requirements
Module: clkgen_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DW, default 16: divisor/counter width.
REQ-003 SHALL have parameter DEF_DIV, default 50: reset divisor of every channel (1 MHz from 50 MHz).
REQ-004 SHALL have port iCLK  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port iRST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iEN  in  NCH  per-channel run enable.
REQ-007 SHALL have port iWR  in  1  divisor write strobe, one cycle.
REQ-008 SHALL have port iWR_CH  in  4  target channel of write.
REQ-009 SHALL have port iWR_DIV  in  DW  divisor value written.
REQ-010 SHALL have port oCLK  out  NCH  per-channel divided clock (registered).
REQ-011 SHALL have port oTICK  out  NCH  per-channel one-cycle pulse per period.
REQ-012 SHALL have port oBUSY  out  NCH  per-channel pending-divisor flag.
REQ-013 SHALL have port oERR  out  1  one-cycle pulse on rejected write.

Function
REQ-014 Each channel SHALL hold an active divisor D, a pending divisor, and a counter cnt counting 0..D-1 then wrapping to 0.
REQ-015 Enabled channel: oTICK[ch] SHALL be 1 for exactly the cycle following the one where cnt==D-1; period = D cycles.
REQ-016 oCLK[ch] SHALL be registered as (cnt < D>>1): D=50 gives 25 high/25 low; odd D=5 gives 2 high/3 low.
REQ-017 iEN[ch]=0 SHALL hold cnt at 0, oCLK[ch]=0, oTICK[ch]=0; on re-enable counting SHALL start from 0 the next cycle.
REQ-018 Accepted write to an enabled channel SHALL load the pending divisor, set oBUSY[ch]=1, and apply at the next wrap (cnt==D-1 -> cnt=0), clearing oBUSY[ch] in the same edge.
REQ-019 Accepted write to a disabled channel SHALL update D immediately; oBUSY[ch] stays 0.
REQ-020 Second write while oBUSY[ch]=1 SHALL overwrite the pending value; only the last is applied.
REQ-021 Write in the same cycle as the channel's wrap SHALL bypass pending and become D at that wrap.
REQ-022 Write with iWR_DIV<2 or iWR_CH>=NCH SHALL be ignored and pulse oERR one cycle later; no state changes.
REQ-023 Channels SHALL be fully independent; one write affects only the addressed channel.
REQ-024 D=2^DW-1 SHALL count without overflow; cnt comparison uses DW bits only.

Reset
REQ-025 iRST_N=0 SHALL asynchronously set every cnt=0, D=DEF_DIV, pending=DEF_DIV, oCLK=0, oTICK=0, oBUSY=0, oERR=0.
REQ-026 Reset asserted mid-period or with a pending write SHALL discard the pending write.
REQ-027 After iRST_N release, an enabled channel's first oTICK SHALL occur DEF_DIV cycles after the first active edge.

Configuration
REQ-028 Macro CLKGEN_SYNC_EN defined: SHALL add input iSYNC (1 bit); iSYNC=1 forces cnt=0 on all enabled channels and applies all pending divisors at that edge, with no oTICK that cycle.
REQ-029 Macro CLKGEN_SYNC_EN undefined: iSYNC SHALL not exist; phase alignment only via reset or iEN.

Verification
REQ-030 Reset, iEN=4'b0001, no writes -> oTICK[0] every 50 cycles, oCLK[0] 25 high/25 low; channels 1..3 stay 0.
REQ-031 Write ch2 D=7 while enabled at cnt=3 -> oBUSY[2]=1 until wrap, old period completes, then 7-cycle period, oCLK 3 high/4 low.
REQ-032 Write D=1 or iWR_CH=5 -> oERR single pulse, all D unchanged, oBUSY unchanged.
REQ-033 Two writes (10 then 20) to ch1 within one period -> period becomes 20; 10 never seen.
REQ-034 Assert iRST_N low mid-period with pending write -> all outputs 0 immediately; after release period 50, pending lost.
REQ-035 With CLKGEN_SYNC_EN, channels at D=50 and D=25 out of phase, pulse iSYNC -> both counters 0, oTICK coincident every 50 cycles.
